// File: rtl/digit_scan_sequencer.sv
// Scan sequencer for an 8-position display/strobe array: walks a 3-bit index
// through the active positions with a blanking gap before each one.
module digit_scan_sequencer #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] digit_mask,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic       slot_start,
  output logic       frame_done
);

  localparam int MAX_LEN = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] SHOW_LOAD  = CW'(CLK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [2:0] first_pos;
  logic [2:0] next_pos;
  logic       last_cycle;
  logic       wrap;
  logic       keep_going;

  // Lowest set bit of the mask; only meaningful when the mask is non-zero.
  always_comb begin
    first_pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (digit_mask[i]) first_pos = 3'(i);
    end
  end

  // First set bit strictly after sel, searching cyclically; k=8 lands back on
  // sel itself, which covers the single-active-bit case.
  always_comb begin
    logic [2:0] p;
    logic       found;
    next_pos = sel;
    found    = 1'b0;
    p        = sel;
    for (int k = 1; k <= 8; k++) begin
      p = sel + 3'(k);
      if (!found && digit_mask[p]) begin
        next_pos = p;
        found    = 1'b1;
      end
    end
  end

  assign last_cycle = (cnt == {{(CW-1){1'b0}}, 1'b1});
  assign wrap       = (next_pos <= sel);
  assign keep_going = run && (digit_mask != 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= 3'd0;
      sel_en     <= 1'b0;
      slot_start <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      slot_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          sel_en <= 1'b0;
          if (keep_going) begin
            sel   <= first_pos;
            state <= BLANK;
            cnt   <= BLANK_LOAD;
          end
        end
        BLANK: begin
          if (last_cycle) begin
            state      <= SHOW;
            cnt        <= SHOW_LOAD;
            sel_en     <= 1'b1;
            slot_start <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SHOW: begin
          // run/mask are only consulted here, so a slot is never cut short.
          if (last_cycle) begin
            sel_en <= 1'b0;
            if (!keep_going) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              sel        <= next_pos;
              state      <= BLANK;
              cnt        <= BLANK_LOAD;
              frame_done <= wrap;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          sel_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
